// File: rtl/mem_loader.sv
// mem_loader: host-side bus master that fills RAM from a byte stream or streams RAM out as bytes
module mem_loader #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 12
) (
   input  logic              CLK_100MHz,
   input  logic              RST_N,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] address,
   output logic [15:0]       dataW,
   output logic              loadM,
   input  logic [15:0]       dataR,
   input  logic              wr_slot
);
   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] RX_HI   = 4'd1;
   localparam logic [3:0] RX_LO   = 4'd2;
   localparam logic [3:0] WRITE   = 4'd3;
   localparam logic [3:0] RD_ADDR = 4'd4;
   localparam logic [3:0] RD_CAP  = 4'd5;
   localparam logic [3:0] TX_HI   = 4'd6;
   localparam logic [3:0] TX_LO   = 4'd7;
   localparam logic [3:0] DONE    = 4'd8;

   logic [3:0]        state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [15:0]       word;
   logic              adv;

   // pointer/counter next values: load on accepted start, step once per finished word
   always_comb begin
      adv   = (state == WRITE && wr_slot) || (state == TX_LO && tx_ready);
      ptr_n = (state == IDLE && start) ? base_addr : adv ? ptr + 1'b1 : ptr;
      cnt_n = (state == IDLE && start) ? word_count : adv ? cnt - 1'b1 : cnt;
   end

   // transfer sequencing
   always_comb begin
      state_n = IDLE;
      case (state)
         IDLE:    state_n = !start ? IDLE : (word_count == '0) ? DONE : mode ? RD_ADDR : RX_HI;
         RX_HI:   state_n = rx_valid ? RX_LO : RX_HI;
         RX_LO:   state_n = rx_valid ? WRITE : RX_LO;
         WRITE:   state_n = !wr_slot ? WRITE : (cnt_n == '0) ? DONE : RX_HI;
         RD_ADDR: state_n = RD_CAP;
         RD_CAP:  state_n = TX_HI;
         TX_HI:   state_n = tx_ready ? TX_LO : TX_HI;
         TX_LO:   state_n = !tx_ready ? TX_LO : (cnt_n == '0) ? DONE : RD_ADDR;
         default: state_n = IDLE;
      endcase
   end

   // state and registered outputs; outputs follow the state being entered so they line up with it
   always_ff @(posedge CLK_100MHz or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         word     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_ready <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         loadM    <= 1'b0;
         address  <= '0;
         dataW    <= '0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         cnt      <= cnt_n;
         busy     <= (state_n != IDLE) || (state == DONE);
         done     <= state == DONE;
         rx_ready <= (state_n == RX_HI) || (state_n == RX_LO);
         tx_valid <= (state_n == TX_HI) || (state_n == TX_LO);
         loadM    <= state_n == WRITE;
         if (state_n == WRITE || state_n == RD_ADDR) address <= ptr_n;
         if (state == RX_HI && rx_valid) word[15:8] <= rx_data;
         if (state == RX_LO && rx_valid) dataW <= {word[15:8], rx_data};
         if (state == RD_CAP) word <= dataR;
         if (state == RD_CAP) tx_data <= dataR[15:8];
         else if (state == TX_HI && tx_ready) tx_data <= word[7:0];
      end
   end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader with a registered RAM model
module tb_mem_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [10:0] base_addr = '0;
   logic [11:0] word_count = '0;
   logic        busy, done;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [10:0] address;
   logic [15:0] data_w;
   logic [15:0] data_r = '0;
   logic        load_m;
   logic        wr_slot = 1'b0;

   logic [15:0] ram [2048];
   logic [7:0]  txq [$];
   int passed = 0, fails = 0, total = 0;
   int wr_mode = 0, tx_mode = 0, cyc = 0;
   int done_cnt = 0, rx_acc = 0, wr_cnt = 0, act = 0, hold_err = 0, hold_cyc = 0, stab_err = 0;
   logic        pl = 1'b0, ps = 1'b0, sv = 1'b0, sr = 1'b0;
   logic [10:0] pa = '0;
   logic [15:0] pdw = '0;
   logic [7:0]  sd = '0;

   mem_loader dut (
      .CLK_100MHz(clk), .RST_N(rst_n), .start(start), .mode(mode),
      .base_addr(base_addr), .word_count(word_count), .busy(busy), .done(done),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .address(address), .dataW(data_w), .loadM(load_m), .dataR(data_r), .wr_slot(wr_slot)
   );

   always #5 clk = ~clk;

   // RAM model plus event monitors sampled on the rising edge
   always @(posedge clk) begin
      data_r <= ram[address];
      if (load_m && wr_slot) begin
         ram[address] = data_w;
         wr_cnt++;
      end
      if (done) done_cnt++;
      if (rx_valid && rx_ready) rx_acc++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (rx_ready || tx_valid || load_m) act++;
      if (pl && !ps && rst_n && (!load_m || address !== pa || data_w !== pdw)) hold_err++;
      if (load_m && !wr_slot) hold_cyc++;
      pl = load_m;
      ps = wr_slot;
      pa = address;
      pdw = data_w;
   end

   // memory-side slot pulses, sink backpressure and tx_data stability tracking
   always @(negedge clk) begin
      cyc++;
      wr_slot = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? (cyc % 10 == 0) : 1'b0;
      if (sv && !sr && tx_data !== sd) stab_err++;
      tx_ready = (tx_mode == 0) || ($urandom_range(0, 1) == 1);
      sv = tx_valid;
      sr = tx_ready;
      sd = tx_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic m, input logic [10:0] b, input logic [11:0] c);
      start = 1'b1;
      mode = m;
      base_addr = b;
      word_count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("rx_timeout", n, 0);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int lim, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, done}, 1);
      @(negedge clk);
   endtask

   initial begin
      int errs;
      int n;
      logic [10:0] a;
      logic [15:0] w;
      for (int i = 0; i < 2048; i++) ram[i] = 16'hFFFF;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_load_m", {31'd0, load_m}, 0);
      chk("rst_rx_ready", {31'd0, rx_ready}, 0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 0);
      chk("rst_address", {21'd0, address}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      wr_mode = 1; done_cnt = 0; wr_cnt = 0; hold_err = 0; hold_cyc = 0;
      issue(1'b0, 11'h010, 12'd2);
      chk("load_busy_rise", {31'd0, busy}, 1);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      wait_done(200, "load_done");
      chk("load_ram_010", {16'd0, ram[11'h010]}, 32'h1234);
      chk("load_ram_011", {16'd0, ram[11'h011]}, 32'hABCD);
      chk("load_writes", wr_cnt, 2);
      chk("load_hold_err", hold_err, 0);
      chk("load_held", {31'd0, hold_cyc >= 5}, 1);
      chk("load_done_cnt", done_cnt, 1);
      chk("load_busy_fall", {31'd0, busy}, 0);

      ram[11'h7FF] = 16'hBEEF; ram[11'h000] = 16'hCAFE;
      wr_mode = 0; tx_mode = 1; txq.delete(); done_cnt = 0; stab_err = 0;
      issue(1'b1, 11'h7FF, 12'd2);
      wait_done(500, "dump_done");
      chk("dump_len", txq.size(), 4);
      if (txq.size() == 4) begin
         chk("dump_b0", {24'd0, txq[0]}, 32'hBE);
         chk("dump_b1", {24'd0, txq[1]}, 32'hEF);
         chk("dump_b2", {24'd0, txq[2]}, 32'hCA);
         chk("dump_b3", {24'd0, txq[3]}, 32'hFE);
      end
      chk("dump_wrap_addr", {21'd0, address}, 0);
      chk("dump_tx_stable", stab_err, 0);
      chk("dump_done_cnt", done_cnt, 1);

      tx_mode = 0; act = 0; done_cnt = 0;
      issue(1'b0, 11'h100, 12'd0);
      chk("zero_done_c1", {31'd0, done}, 0);
      chk("zero_busy_c1", {31'd0, busy}, 1);
      @(negedge clk);
      chk("zero_done_c2", {31'd0, done}, 1);
      @(negedge clk);
      chk("zero_done_c3", {31'd0, done}, 0);
      chk("zero_busy_c3", {31'd0, busy}, 0);
      chk("zero_activity", act, 0);

      done_cnt = 0; rx_acc = 0; txq.delete(); ram[11'h020] = 16'h0000;
      issue(1'b0, 11'h020, 12'd1);
      send_byte(8'h11);
      start = 1'b1; mode = 1'b1; base_addr = 11'h030; word_count = 12'd5;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h22);
      wait_done(200, "sb_done");
      repeat (20) @(negedge clk);
      chk("sb_ram_020", {16'd0, ram[11'h020]}, 32'h1122);
      chk("sb_done_cnt", done_cnt, 1);
      chk("sb_tx_bytes", txq.size(), 0);
      chk("sb_busy", {31'd0, busy}, 0);
      rx_data = 8'h77; rx_valid = 1'b1;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      chk("extra_rx_ignored", rx_acc, 2);

      wr_cnt = 0;
      issue(1'b0, 11'h400, 12'd2048);
      for (int i = 0; i < 2048; i++) begin
         a = 11'h400 + 11'(i);
         w = {5'd0, a} ^ 16'h5A5A;
         send_byte(w[15:8]);
         send_byte(w[7:0]);
      end
      wait_done(100, "sweep_load_done");
      chk("sweep_writes", wr_cnt, 2048);
      errs = 0;
      for (int i = 0; i < 2048; i++) if (ram[i] !== (16'(i) ^ 16'h5A5A)) errs++;
      chk("sweep_ram", errs, 0);
      txq.delete();
      issue(1'b1, 11'h400, 12'd2048);
      wait_done(10000, "sweep_dump_done");
      chk("sweep_dump_len", txq.size(), 4096);
      errs = 0;
      if (txq.size() == 4096)
         for (int i = 0; i < 2048; i++) begin
            a = 11'h400 + 11'(i);
            w = {5'd0, a} ^ 16'h5A5A;
            if (txq[2*i] !== w[15:8] || txq[2*i+1] !== w[7:0]) errs++;
         end
      chk("sweep_dump_data", errs, 0);

      wr_mode = 2; ram[11'h050] = 16'h7777; done_cnt = 0;
      issue(1'b0, 11'h050, 12'd1);
      send_byte(8'h99); send_byte(8'h88);
      n = 0;
      while (load_m !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_in_write", {31'd0, load_m}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_load_m", {31'd0, load_m}, 0);
      chk("rst_async_busy", {31'd0, busy}, 0);
      chk("rst_async_tx_valid", {31'd0, tx_valid}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; wr_mode = 0;
      repeat (5) @(negedge clk);
      chk("rst_ram_unchanged", {16'd0, ram[11'h050]}, 32'h7777);
      chk("rst_idle_busy", {31'd0, busy}, 0);
      chk("rst_idle_rx_ready", {31'd0, rx_ready}, 0);
      chk("rst_idle_load_m", {31'd0, load_m}, 0);
      chk("rst_no_done", done_cnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mem_loader.md
# mem_loader

Bus master for the Hack data-memory port: drives `address`, `dataW` and `loadM`, and consumes `dataR`. It either fills a RAM region from an incoming byte stream (LOAD) or streams a RAM region out as bytes (DUMP), so a host link can load programs or data and read results back without the CPU. It sits beside the CPU on the memory port; the top level muxes its port with the CPU's while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 11: memory address width; the address space is 2^ADDR_W words.
- `CNT_W`, 12: width of `word_count`; must hold the value 2^ADDR_W.

Ports:
- `CLK_100MHz` in 1: the single clock; all logic is on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command strobe; sampled only in IDLE.
- `mode` in 1: command type, 0 = LOAD, 1 = DUMP; sampled with `start`.
- `base_addr` in ADDR_W: first word address; sampled with `start`.
- `word_count` in CNT_W: number of words to transfer; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: inbound byte stream.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: outbound byte stream.
- `address` out ADDR_W, `dataW` out 16, `loadM` out 1: memory request signals.
- `dataR` in 16: memory read data. It is registered, so it reflects `address` one cycle after that address is presented.
- `wr_slot` in 1: pulse from the memory side marking the cycle in which a held `loadM` is committed.

## Operation
- All outputs are registered. Under reset (`RST_N` = 0) every output is 0 and the state is IDLE.
- Bytes form words big-endian: the first byte is `[15:8]`, the second is `[7:0]`.
- States: IDLE, RX_HI, RX_LO, WRITE, RD_ADDR, RD_CAP, TX_HI, TX_LO, DONE.
- IDLE, on `start`: latch `base_addr` into the address pointer and `word_count` into the remaining-word counter.
  - If the counter is 0, go to DONE.
  - Otherwise go to RX_HI for LOAD, or RD_ADDR for DUMP.
  - `start` in any other state is ignored.
- RX_HI: `rx_ready` = 1. On `rx_valid`, latch the high byte and go to RX_LO.
- RX_LO: `rx_ready` = 1. On `rx_valid`, latch the low byte and go to WRITE.
- WRITE: `loadM` = 1, with `address` = pointer and `dataW` = assembled word, all held stable.
  - Stay in WRITE until a cycle with `wr_slot` = 1; the write commits in that cycle.
  - Then increment the pointer modulo 2^ADDR_W and decrement the counter.
  - If the counter is now 0, go to DONE; otherwise go to RX_HI.
  - `loadM` is 0 in every other state.
- RD_ADDR: drive `address` = pointer, then go to RD_CAP.
- RD_CAP: capture `dataR` into the word register, then go to TX_HI.
- TX_HI: `tx_valid` = 1, `tx_data` = word[15:8]. Hold until `tx_ready`, then go to TX_LO.
- TX_LO: `tx_valid` = 1, `tx_data` = word[7:0]. Hold until `tx_ready`.
  - Then increment the pointer, decrement the counter, and go to DONE or RD_ADDR.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.

## Timing
- Handshakes:
  - A byte moves on any cycle where valid and ready are both 1.
  - `tx_data` is stable while `tx_valid` = 1 and `tx_ready` = 0.
  - `rx_ready` is 1 only in RX_HI and RX_LO.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- LOAD throughput: at least 3 cycles per word (high byte, low byte, WRITE with `wr_slot` already high).
- DUMP throughput: at least 4 cycles per word (RD_ADDR, RD_CAP, TX_HI, TX_LO with `tx_ready` held high).
- Address wrap: 2^ADDR_W − 1 is followed by 0. `word_count` = 2048 starting from any base touches every word exactly once.
- `word_count` = 0: `done` pulses 2 cycles after `start`, with no `rx_ready`, `tx_valid` or `loadM` activity.
- Extra input bytes arriving after the last word are left unaccepted (`rx_ready` = 0).
- Reset asserted mid-transfer: the transfer aborts immediately and `loadM` falls asynchronously. A word held in WRITE without a `wr_slot` is not written. No `done` is issued.

## Test plan
- Reset: assert `RST_N` = 0 in the middle of WRITE. Required: `loadM`, `busy` and `tx_valid` read 0 at once; after release the block sits in IDLE and the target word is unchanged.
- LOAD with write gating: base 0x010, count 2, bytes 12 34 AB CD, `wr_slot` pulsed every 10 cycles. Required: `loadM` is held until each `wr_slot`; RAM[0x010] = 0x1234 and RAM[0x011] = 0xABCD; a single `done` pulse.
- DUMP with backpressure: RAM[0x7FF] = 0xBEEF and RAM[0x000] = 0xCAFE; base 0x7FF, count 2; `tx_ready` toggled randomly. Required: bytes BE EF CA FE in order, and the address wraps to 0x000.
- Zero count: `word_count` = 0. Required: `done` 2 cycles after `start`, with no bus or stream activity.
- `start` while busy: a second `start` is issued during a LOAD. Required: it is ignored, the original transfer completes, and exactly one `done` is issued.
- Full sweep: LOAD 2048 words, with data equal to address XOR 0x5A5A, starting from base 0x400, then DUMP them back. Required: every byte read back matches what was loaded.
